sn74xx_gate_bank: RTL and testbench

//  Parametrised successor to the quad-NAND TTL model.

---
 rtl/ttl_pkg.sv | 21 ++
 rtl/sn74xx_gate_bank_if.sv | 17 +
 rtl/ttl_delay_line.sv | 46 ++++
 rtl/sn74xx_gate_bank.sv | 115 +++++++++++
 tb/tb_sn74xx_gate_bank.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ttl_pkg.sv
// Shared definitions for the TTL gate models: gate-function encodings and the
// power-good qualification used by every package model.
package ttl_pkg;

  localparam logic [2:0] MODE_NAND = 3'b000;
  localparam logic [2:0] MODE_NOR  = 3'b001;
  localparam logic [2:0] MODE_AND  = 3'b010;
  localparam logic [2:0] MODE_OR   = 3'b011;
  localparam logic [2:0] MODE_XOR  = 3'b100;
  localparam logic [2:0] MODE_XNOR = 3'b101;

  // Unknown or floating supply pins count as not powered.
  function automatic logic ttl_pg(input logic vcc, input logic gnd);
    return (vcc === 1'b1) && (gnd === 1'b0);
  endfunction

  function automatic logic ttl_mode_illegal(input logic [2:0] mode);
    return (mode > MODE_XNOR);
  endfunction

endpackage

// File: rtl/sn74xx_gate_bank_if.sv
// Pin bundle of the parametrised TTL gate package: supply, inputs and outputs.
interface sn74xx_gate_bank_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 2
);
  logic                         vcc;
  logic                         gnd;
  logic [2:0]                   mode;
  logic [CHANNELS*WIDTH-1:0]    a;
  logic [CHANNELS-1:0]          y;
  logic                         y_valid;
  logic                         mode_err;
  logic                         pwr_lost;

  modport master (output vcc, gnd, mode, a, input y, y_valid, mode_err, pwr_lost);
  modport slave  (input vcc, gnd, mode, a, output y, y_valid, mode_err, pwr_lost);
endinterface

// File: rtl/ttl_delay_line.sv
// Register chain modelling propagation delay; the whole chain freezes while hold=1.
module ttl_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [W-1:0] dout_d
);

  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (!hold) begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end else begin
      stage_d[0] = stage_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= {W{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout   = stage_q[DEPTH-1];
  assign dout_d = stage_d[DEPTH-1];

endmodule

// File: rtl/sn74xx_gate_bank.sv
// Parametrised multi-gate TTL package with run-time gate function and pipelined delay.
// Optional feature macro: SN74XX_TOGGLE_CNT_EN adds the toggle_cnt output.
module sn74xx_gate_bank
  import ttl_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 2,
  parameter int TPD_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
`ifdef SN74XX_TOGGLE_CNT_EN
  output logic [15:0]         toggle_cnt,
`endif
  sn74xx_gate_bank_if.slave   bus
);

  localparam int FW = $clog2(TPD_CYCLES + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(TPD_CYCLES);

  logic                pg_s;
  logic [CHANNELS-1:0] gate_s;
  logic [CHANNELS-1:0] y_s;
  logic [CHANNELS-1:0] y_next_s;
  logic [FW-1:0]       fill_q, fill_d;
  logic                y_valid_q, y_valid_d;
  logic                mode_err_q, mode_err_d;
  logic                pwr_lost_q, pwr_lost_d;

  assign pg_s = ttl_pg(bus.vcc, bus.gnd);

  always_comb begin
    gate_s = {CHANNELS{1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      case (bus.mode)
        MODE_NAND: gate_s[k] = ~(&bus.a[k*WIDTH +: WIDTH]);
        MODE_NOR:  gate_s[k] = ~(|bus.a[k*WIDTH +: WIDTH]);
        MODE_AND:  gate_s[k] =   &bus.a[k*WIDTH +: WIDTH];
        MODE_OR:   gate_s[k] =   |bus.a[k*WIDTH +: WIDTH];
        MODE_XOR:  gate_s[k] =   ^bus.a[k*WIDTH +: WIDTH];
        MODE_XNOR: gate_s[k] = ~(^bus.a[k*WIDTH +: WIDTH]);
        default:   gate_s[k] = ~(&bus.a[k*WIDTH +: WIDTH]);
      endcase
    end
  end

  ttl_delay_line #(.W(CHANNELS), .DEPTH(TPD_CYCLES)) u_delay (
    .clk    (clk),
    .rst    (rst),
    .hold   (!pg_s),
    .din    (gate_s),
    .dout   (y_s),
    .dout_d (y_next_s)
  );

  // Fill counter restarts on power loss so y_valid only returns once the chain is refilled.
  always_comb begin
    if (!pg_s) begin
      fill_d = {FW{1'b0}};
    end else if (fill_q != FILL_MAX) begin
      fill_d = fill_q + FW'(1);
    end else begin
      fill_d = fill_q;
    end
    y_valid_d  = (fill_d == FILL_MAX);
    pwr_lost_d = !pg_s;
    mode_err_d = mode_err_q | (pg_s & ttl_mode_illegal(bus.mode));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q     <= {FW{1'b0}};
      y_valid_q  <= 1'b0;
      mode_err_q <= 1'b0;
      pwr_lost_q <= 1'b0;
    end else begin
      fill_q     <= fill_d;
      y_valid_q  <= y_valid_d;
      mode_err_q <= mode_err_d;
      pwr_lost_q <= pwr_lost_d;
    end
  end

  assign bus.y        = y_s;
  assign bus.y_valid  = y_valid_q;
  assign bus.mode_err = mode_err_q;
  assign bus.pwr_lost = pwr_lost_q;

`ifdef SN74XX_TOGGLE_CNT_EN
  logic [15:0] toggle_cnt_q, toggle_cnt_d;

  // A change counts when the post-edge y differs and is flagged valid.
  always_comb begin
    if (y_valid_d && (y_next_s != y_s) && (toggle_cnt_q != 16'hFFFF)) begin
      toggle_cnt_d = toggle_cnt_q + 16'd1;
    end else begin
      toggle_cnt_d = toggle_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_cnt_q <= 16'd0;
    end else begin
      toggle_cnt_q <= toggle_cnt_d;
    end
  end

  assign toggle_cnt = toggle_cnt_q;
`else
  logic unused_s;
  assign unused_s = ^y_next_s;
`endif

endmodule

// File: tb/tb_sn74xx_gate_bank.sv
// Self-checking bench for sn74xx_gate_bank: a TPD=1 and a TPD=3 instance share stimulus,
// each compared against a queue-based scoreboard every edge.
module tb_sn74xx_gate_bank;
  import ttl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vcc_s = 1'b1;
  logic       gnd_s = 1'b0;
  logic [2:0] mode_s = 3'b000;
  logic [7:0] a_s = 8'hFF;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sn74xx_gate_bank_if #(.CHANNELS(4), .WIDTH(2)) if1 ();
  sn74xx_gate_bank_if #(.CHANNELS(4), .WIDTH(2)) if3 ();

  assign if1.vcc = vcc_s;  assign if1.gnd = gnd_s;
  assign if1.mode = mode_s; assign if1.a = a_s;
  assign if3.vcc = vcc_s;  assign if3.gnd = gnd_s;
  assign if3.mode = mode_s; assign if3.a = a_s;

`ifdef SN74XX_TOGGLE_CNT_EN
  logic [15:0] tog1_s, tog3_s;
`endif

  sn74xx_gate_bank #(.CHANNELS(4), .WIDTH(2), .TPD_CYCLES(1)) dut1 (
    .clk (clk), .rst (rst),
`ifdef SN74XX_TOGGLE_CNT_EN
    .toggle_cnt (tog1_s),
`endif
    .bus (if1.slave)
  );

  sn74xx_gate_bank #(.CHANNELS(4), .WIDTH(2), .TPD_CYCLES(3)) dut3 (
    .clk (clk), .rst (rst),
`ifdef SN74XX_TOGGLE_CNT_EN
    .toggle_cnt (tog3_s),
`endif
    .bus (if3.slave)
  );

  // Scoreboard state, index 0 = TPD 1 instance, index 1 = TPD 3 instance.
  int         tpd [2] = '{1, 3};
  logic [3:0] sbq [2][$];
  logic [3:0] ey [2];
  int         fill [2];
  logic       ev [2], merr [2], plost [2];
  int         tog [2];

  function automatic logic [3:0] ref_gate(input logic [2:0] m, input logic [7:0] a);
    logic [3:0] r;
    logic p0, p1;
    r = 4'h0;
    for (int g = 0; g < 4; g++) begin
      p0 = a[2*g];
      p1 = a[2*g+1];
      case (m)
        3'b001:  r[g] = !(p0 || p1);
        3'b010:  r[g] = p0 && p1;
        3'b011:  r[g] = p0 || p1;
        3'b100:  r[g] = (p0 != p1);
        3'b101:  r[g] = (p0 == p1);
        default: r[g] = !(p0 && p1);
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("y_tpd1",        16'(if1.y),        16'(ey[0]));
    check("y_valid_tpd1",  16'(if1.y_valid),  16'(ev[0]));
    check("mode_err_tpd1", 16'(if1.mode_err), 16'(merr[0]));
    check("pwr_lost_tpd1", 16'(if1.pwr_lost), 16'(plost[0]));
    check("y_tpd3",        16'(if3.y),        16'(ey[1]));
    check("y_valid_tpd3",  16'(if3.y_valid),  16'(ev[1]));
    check("mode_err_tpd3", 16'(if3.mode_err), 16'(merr[1]));
    check("pwr_lost_tpd3", 16'(if3.pwr_lost), 16'(plost[1]));
`ifdef SN74XX_TOGGLE_CNT_EN
    check("toggle_tpd1", tog1_s, 16'(tog[0]));
    check("toggle_tpd3", tog3_s, 16'(tog[1]));
`endif
  endtask

  // One clock edge: capture what the pins show, advance the scoreboard, then compare.
  task automatic step();
    logic       pg;
    logic [3:0] f;
    logic [3:0] prev_y;
    pg = (vcc_s === 1'b1) && (gnd_s === 1'b0);
    f  = ref_gate(mode_s, a_s);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        sbq[d].delete();
        ey[d] = 4'h0; fill[d] = 0; ev[d] = 1'b0;
        merr[d] = 1'b0; plost[d] = 1'b0; tog[d] = 0;
      end else begin
        prev_y   = ey[d];
        plost[d] = !pg;
        if (pg) begin
          sbq[d].push_back(f);
          if (sbq[d].size() == tpd[d]) ey[d] = sbq[d].pop_front();
          if (fill[d] < tpd[d]) fill[d]++;
          if (mode_s > 3'b101) merr[d] = 1'b1;
        end else begin
          fill[d] = 0;
        end
        ev[d] = (fill[d] == tpd[d]);
        if (ev[d] && (ey[d] != prev_y) && (tog[d] != 65535)) tog[d]++;
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    // Reset with all inputs high.
    rst = 1'b1; a_s = 8'hFF;
    step(); step();
    check("reset_y", 16'(if1.y), 16'h0000);
    check("reset_valid", 16'(if1.y_valid), 16'h0000);

    // NAND on the default package.
    rst = 1'b0; mode_s = MODE_NAND; a_s = 8'b11_01_10_11;
    step();
    check("nand_y", 16'(if1.y), 16'h0006);
    check("nand_valid", 16'(if1.y_valid), 16'h0001);

    // Mode travels with data through the 3-deep instance.
    rst = 1'b1; step();
    rst = 1'b0; a_s = 8'h00; mode_s = MODE_NOR; step();
    mode_s = MODE_XOR; step();
    check("tpd3_valid_edge2", 16'(if3.y_valid), 16'h0000);
    step();
    check("tpd3_nor_y", 16'(if3.y), 16'h000F);
    check("tpd3_valid_edge3", 16'(if3.y_valid), 16'h0001);
    step();
    check("tpd3_xor_y", 16'(if3.y), 16'h0000);

    // Power loss: outputs frozen while inputs move, X/Z on a supply pin is not power.
    mode_s = MODE_AND; a_s = 8'hA5; step();
    vcc_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_s = 8'(i * 8'h3C);
      step();
    end
    check("pwr_lost_set", 16'(if1.pwr_lost), 16'h0001);
    vcc_s = 1'bx; step();
    vcc_s = 1'b1; gnd_s = 1'bz; step();
    check("gnd_z_valid", 16'(if3.y_valid), 16'h0000);
    gnd_s = 1'b0; mode_s = MODE_XNOR; a_s = 8'h96; step();
    check("pwr_restored", 16'(if1.pwr_lost), 16'h0000);
    step(); step();
    check("tpd3_valid_restore", 16'(if3.y_valid), 16'h0001);

    // Illegal mode computes NAND and latches the sticky flag.
    mode_s = 3'b111; a_s = 8'hFF; step();
    check("illegal_nand_y", 16'(if1.y), 16'h0000);
    mode_s = MODE_OR; a_s = 8'h5A; step(); step();
    check("mode_err_sticky", 16'(if1.mode_err), 16'h0001);
    rst = 1'b1; step();
    check("mode_err_cleared", 16'(if1.mode_err), 16'h0000);
    rst = 1'b0;

    // Random legal-mode traffic.
    for (int i = 0; i < 20; i++) begin
      mode_s = 3'($urandom_range(5, 0));
      a_s    = 8'($urandom);
      step();
    end

`ifdef SN74XX_TOGGLE_CNT_EN
    rst = 1'b1; step();
    rst = 1'b0; mode_s = MODE_NAND;
    for (int i = 0; i < 10; i++) begin
      a_s = (i % 2 == 0) ? 8'h00 : 8'hFF;
      step();
    end
    check("toggle_cnt_10", tog1_s, 16'd10);
    rst = 1'b1; step();
    check("toggle_cnt_rst", tog1_s, 16'd0);
    rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
